// File: rtl/game_input_pkg.sv
// Shared types and constants for the game button input path.
package game_input_pkg;

    localparam int NUM_BTN   = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_NEW   = 4;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_NEW   = 3'd4
    } move_dir_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/press_latch.sv
// Per-button rising-edge detect and pending flag; a new press or repeat wins over a same-cycle grant.
module press_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic grant,
    input  logic rep_set,
    output logic pending
);

    logic prev;
    logic press;

    assign press = level & ~prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev <= level;
            if (press || rep_set) begin
                pending <= 1'b1;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/move_input_arbiter.sv
// Button presses to a valid/ready stream of move commands; new game first, round-robin among directions.
// Optional hold-to-repeat for direction buttons when AUTO_REPEAT_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | arbitrate pending flags, load move_dir with the winner
//   ST_OFFER | move_valid high, move_dir frozen until move_ready
module move_input_arbiter
    import game_input_pkg::*;
#(
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 3_750_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic               move_valid,
    output logic [2:0]         move_dir,
    input  logic               move_ready
);

    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 24'hFF_FFFF ||
        REPEAT_RATE  < 2 || REPEAT_RATE  > 24'hFF_FFFF) begin : g_bad_repeat_cfg
        $error("move_input_arbiter: repeat parameters out of range");
    end

    arb_state_t         state_q, state_d;
    move_dir_t          move_dir_q, move_dir_d;
    move_dir_t          winner;
    logic [1:0]         last_dir_q, last_dir_d;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] rep_set;
    logic [3:0]         dir_pending;
    logic               handshake;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_latch
        press_latch u_press_latch (
            .clk     (clk),
            .rst_n   (rst_n),
            .level   (btn_level[i]),
            .grant   (grant[i]),
            .rep_set (rep_set[i]),
            .pending (pending[i])
        );
    end

    assign dir_pending = {pending[BTN_LEFT], pending[BTN_DOWN], pending[BTN_RIGHT], pending[BTN_UP]};
    assign handshake   = (state_q == ST_OFFER) && move_ready;
    assign move_valid  = (state_q == ST_OFFER);
    assign move_dir    = move_dir_q;

    // Round-robin search starts just after the last granted direction.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        idx    = '0;
        found  = 1'b0;
        winner = DIR_UP;
        if (pending[BTN_NEW]) begin
            winner = DIR_NEW;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                idx = last_dir_q + 2'(i);
                if (!found && dir_pending[idx]) begin
                    winner = move_dir_t'({1'b0, idx});
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        move_dir_d = move_dir_q;
        last_dir_d = last_dir_q;
        grant      = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    state_d    = ST_OFFER;
                    move_dir_d = winner;
                end
            end
            ST_OFFER: begin
                if (move_ready) begin
                    grant[move_dir_q] = 1'b1;
                    if (move_dir_q != DIR_NEW) begin
                        last_dir_d = move_dir_q[1:0];
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            move_dir_q <= DIR_UP;
            last_dir_q <= 2'd3;
        end else begin
            state_q    <= state_d;
            move_dir_q <= move_dir_d;
            last_dir_q <= last_dir_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [23:0] DELAY_TC = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RATE_TC  = 24'(REPEAT_RATE - 1);

    logic [23:0] rep_cnt;
    logic [1:0]  rep_btn;
    logic        rep_active;
    logic        rep_first;
    logic        retrack;
    logic        rep_fire;

    // Granting the tracked button again (a repeat) must not restart the hold timing.
    assign retrack  = handshake &&
                      (move_dir_q == DIR_NEW || !rep_active || move_dir_q[1:0] != rep_btn);
    assign rep_fire = rep_active && !retrack && btn_level[rep_btn] &&
                      (rep_cnt == (rep_first ? DELAY_TC : RATE_TC));
    assign rep_set  = NUM_BTN'(rep_fire) << rep_btn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt    <= '0;
            rep_btn    <= '0;
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
        end else if (retrack) begin
            rep_active <= (move_dir_q != DIR_NEW);
            rep_btn    <= move_dir_q[1:0];
            rep_cnt    <= '0;
            rep_first  <= 1'b1;
        end else if (rep_active) begin
            if (!btn_level[rep_btn]) begin
                rep_active <= 1'b0;
                rep_cnt    <= '0;
            end else if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 24'd1;
            end
        end
    end
`else
    assign rep_set = '0;
`endif

endmodule

// File: tb/tb_move_input_arbiter.sv
// Directed bench for move_input_arbiter: a scoreboard of expected commands checked at each handshake.
module tb_move_input_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_level;
    logic       move_valid;
    logic [2:0] move_dir;
    logic       move_ready;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] sb[$];

    move_input_arbiter #(
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_level  (btn_level),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Every accepted command must be the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && move_valid && move_ready) begin
            check("cmd_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) check("cmd_dir", 32'(move_dir), 32'(sb.pop_front()));
        end
    end

    initial begin
        btn_level  = '0;
        move_ready = 1'b0;
        rst_n      = 1'b0;
        step(2);
        check("rst_valid", 32'(move_valid), 0);
        check("rst_dir", 32'(move_dir), 0);
        rst_n = 1'b1;
        move_ready = 1'b1;
        step(1);

        // single press of down, 3 cycles wide
        btn_level = 5'b00100;
        sb.push_back(3'd2);
        step(1);
        check("lat_edge_k", 32'(move_valid), 0);
        step(1);
        check("lat_valid", 32'(move_valid), 1);
        check("lat_dir", 32'(move_dir), 2);
        step(1);
        check("pulse_low", 32'(move_valid), 0);
        btn_level = '0;
        step(6);
        check("single_drained", 32'(sb.size()), 0);

        // all five at once right after reset
        do_reset();
        btn_level = 5'b11111;
        sb.push_back(3'd4); sb.push_back(3'd0); sb.push_back(3'd1);
        sb.push_back(3'd2); sb.push_back(3'd3);
        step(10);
        check("thru_10", 32'(sb.size()), 1);
        step(1);
        check("thru_11", 32'(sb.size()), 0);
        btn_level = '0;
        step(3);

        // backpressure: right offered, up arrives while waiting
        move_ready = 1'b0;
        btn_level  = 5'b00010;
        sb.push_back(3'd1);
        step(2);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 32'({move_valid, move_dir}), 32'h9);
            if (i == 2) begin
                btn_level = 5'b00011;
                sb.push_back(3'd0);
            end
            step(1);
        end
        move_ready = 1'b1;
        step(5);
        btn_level = '0;
        step(2);
        check("bp_drained", 32'(sb.size()), 0);

        // after left, the search wraps to up first
        btn_level = 5'b01000;
        sb.push_back(3'd3);
        step(4);
        btn_level = '0;
        step(2);
        btn_level = 5'b00101;
        sb.push_back(3'd0); sb.push_back(3'd2);
        step(8);
        btn_level = '0;
        step(2);
        check("rr_left_drained", 32'(sb.size()), 0);

        // after right, down is searched before up
        btn_level = 5'b00010;
        sb.push_back(3'd1);
        step(4);
        btn_level = '0;
        step(2);
        btn_level = 5'b00101;
        sb.push_back(3'd2); sb.push_back(3'd0);
        step(8);
        btn_level = '0;
        step(2);
        check("rr_right_drained", 32'(sb.size()), 0);

        // reset while a command is offered loses it
        move_ready = 1'b0;
        btn_level  = 5'b00001;
        step(2);
        check("mo_valid", 32'(move_valid), 1);
        rst_n     = 1'b0;
        btn_level = '0;
        step(1);
        check("mo_drop", 32'(move_valid), 0);
        check("mo_dir", 32'(move_dir), 0);
        rst_n      = 1'b1;
        move_ready = 1'b1;
        step(8);
        check("mo_quiet", 32'(move_valid), 0);

        // held left for 20 cycles
        btn_level = 5'b01000;
        sb.push_back(3'd3);
`ifdef AUTO_REPEAT_EN
        sb.push_back(3'd3); sb.push_back(3'd3); sb.push_back(3'd3);
`endif
        step(20);
        btn_level = '0;
        step(10);
        check("hold_drained", 32'(sb.size()), 0);
        check("hold_idle", 32'(move_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
